// File: rtl/tile_palette_ram_pkg.sv
// tile_pkg: shared types and constants for the tile palette RAM.
//   rgb_t          - packed {red, green, blue} colour at the default channel width
//   wr_state_e     - write-port FSM states
//   chan_max()     - all-ones value for a channel of the given width
//   key_colour()   - green key colour {0, max, 0}, right-aligned to 3*cw bits
//   default_entry()- reset contents of one palette entry (same in every bank)
package tile_pkg;

    localparam int RGB_CHAN_W = 4;
    // Upper bound on channel width supported by the constant helpers below.
    localparam int MAX_CHAN_W = 16;

    typedef struct packed {
        logic [RGB_CHAN_W-1:0] red;
        logic [RGB_CHAN_W-1:0] green;
        logic [RGB_CHAN_W-1:0] blue;
    } rgb_t;

    typedef enum logic {
        WR_IDLE = 1'b0,
        WR_ACK  = 1'b1
    } wr_state_e;

    function automatic logic [3*MAX_CHAN_W-1:0] chan_max(input int cw);
        logic [3*MAX_CHAN_W-1:0] m;
        m = '0;
        for (int b = 0; b < MAX_CHAN_W; b++)
            if (b < cw) m[b] = 1'b1;
        return m;
    endfunction

    function automatic logic [3*MAX_CHAN_W-1:0] key_colour(input int cw);
        return chan_max(cw) << cw;
    endfunction

    // Entry 1 is pure blue, everything else is the green key colour.
    function automatic logic [3*MAX_CHAN_W-1:0] default_entry(input int idx, input int cw);
        return (idx == 1) ? chan_max(cw) : key_colour(cw);
    endfunction

endpackage

// File: rtl/tile_palette_ram_if.sv
// tile_palette_ram_if: lookup, write and frame-tick signals of the palette.
//   lookup : rd_valid, pal_sel, index -> red, green, blue, out_valid, transparent
//   write  : wr_req, wr_bank, wr_index, wr_data -> wr_ack
//   frame  : frame_tick (colour-cycling advance)
// master = requester side (video/CPU), slave = palette RAM.
interface tile_palette_ram_if #(
    parameter int INDEX_W = 4,
    parameter int CHAN_W  = 4,
    parameter int BANK_W  = 1
);
    logic                 rd_valid;
    logic [BANK_W-1:0]    pal_sel;
    logic [INDEX_W-1:0]   index;
    logic [CHAN_W-1:0]    red;
    logic [CHAN_W-1:0]    green;
    logic [CHAN_W-1:0]    blue;
    logic                 out_valid;
    logic                 transparent;
    logic                 wr_req;
    logic [BANK_W-1:0]    wr_bank;
    logic [INDEX_W-1:0]   wr_index;
    logic [3*CHAN_W-1:0]  wr_data;
    logic                 wr_ack;
    logic                 frame_tick;

    modport master (
        output rd_valid, pal_sel, index, wr_req, wr_bank, wr_index, wr_data, frame_tick,
        input  red, green, blue, out_valid, transparent, wr_ack
    );

    modport slave (
        input  rd_valid, pal_sel, index, wr_req, wr_bank, wr_index, wr_data, frame_tick,
        output red, green, blue, out_valid, transparent, wr_ack
    );
endinterface

// File: rtl/tile_palette_ram_cycle.sv
// palette_cycle_ctr: frame-synchronous colour-cycling offset and index remap.
//   clk, rst    - clock, synchronous active-high reset (offset -> 0)
//   frame_tick  - advance offset by one, wrapping after LEN-1
//   idx_in      - raw colour index
//   idx_out     - effective index; rotated within [CYC_LO, CYC_HI], else unchanged
module palette_cycle_ctr #(
    parameter int INDEX_W = 4,
    parameter int CYC_LO  = 1,
    parameter int CYC_HI  = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               frame_tick,
    input  logic [INDEX_W-1:0] idx_in,
    output logic [INDEX_W-1:0] idx_out
);
    localparam logic [INDEX_W:0]   LO_X    = (INDEX_W+1)'(CYC_LO);
    localparam logic [INDEX_W:0]   HI_X    = (INDEX_W+1)'(CYC_HI);
    localparam logic [INDEX_W:0]   LEN_X   = (INDEX_W+1)'(CYC_HI - CYC_LO + 1);
    localparam logic [INDEX_W-1:0] LO_N    = INDEX_W'(CYC_LO);
    localparam logic [INDEX_W-1:0] OFF_MAX = INDEX_W'(CYC_HI - CYC_LO);

    logic [INDEX_W-1:0] off;
    logic [INDEX_W:0]   idx_x;
    logic [INDEX_W:0]   rel;

    always_ff @(posedge clk) begin
        if (rst)
            off <= '0;
        else if (frame_tick)
            off <= (off == OFF_MAX) ? '0 : off + 1'b1;
    end

    // One extra bit so (idx - lo + off) cannot overflow; both terms are < LEN,
    // so a single conditional subtract is the modulo.
    always_comb begin
        idx_x   = {1'b0, idx_in};
        rel     = idx_x - LO_X + {1'b0, off};
        if (rel >= LEN_X) rel = rel - LEN_X;
        idx_out = idx_in;
        if (idx_x >= LO_X && idx_x <= HI_X)
            idx_out = rel[INDEX_W-1:0] + LO_N;
    end
endmodule

// File: rtl/tile_palette_ram.sv
// tile_palette_ram: runtime-writable multi-bank palette, index -> 12-bit RGB.
//   Clk, Reset - clock, synchronous active-high reset (reloads default palette)
//   bus        - tile_palette_ram_if.slave: 2-cycle lookup port, req/ack write
//                port, frame_tick
// Optional feature: define TILE_PALETTE_CYCLE_EN to rotate indices CYC_LO..CYC_HI
// by a per-frame offset; otherwise frame_tick is ignored.
module tile_palette_ram
    import tile_pkg::*;
#(
    parameter int INDEX_W = 4,
    parameter int CHAN_W  = 4,
    parameter int NUM_PAL = 2,
    parameter int CYC_LO  = 1,
    parameter int CYC_HI  = 3
) (
    input  logic             Clk,
    input  logic             Reset,
    tile_palette_ram_if.slave bus
);
    localparam int BANK_W  = (NUM_PAL > 1) ? $clog2(NUM_PAL) : 1;
    localparam int ENTRIES = 2**INDEX_W;
    localparam int RGB_W   = 3*CHAN_W;
    localparam int STAGES  = 2;

    logic [RGB_W-1:0]   mem [NUM_PAL][ENTRIES];

    wr_state_e          state_q, state_d;
    logic               wr_en;
    logic               wr_bank_ok;

    logic [STAGES:1]    vld_pipe;
    logic [BANK_W-1:0]  s1_bank;
    logic [INDEX_W-1:0] s1_idx;
    logic [INDEX_W-1:0] eff_idx;
    logic               rd_bank_ok;
    logic [RGB_W-1:0]   rgb_q;
    logic               trans_q;

    assign wr_bank_ok = int'(bus.wr_bank) < NUM_PAL;
    assign rd_bank_ok = int'(s1_bank) < NUM_PAL;

    // ---------------- write FSM ----------------
    always_ff @(posedge Clk) begin
        if (Reset) state_q <= WR_IDLE;
        else       state_q <= state_d;
    end

    // Out-of-range banks still walk through ACK, they just never touch the array.
    always_comb begin
        state_d = state_q;
        wr_en   = 1'b0;
        case (state_q)
            WR_IDLE: if (bus.wr_req) begin
                state_d = WR_ACK;
                wr_en   = wr_bank_ok;
            end
            WR_ACK:  state_d = WR_IDLE;
            default: state_d = WR_IDLE;
        endcase
    end

    assign bus.wr_ack = (state_q == WR_ACK);

    // ---------------- palette storage ----------------
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int b = 0; b < NUM_PAL; b++)
                for (int e = 0; e < ENTRIES; e++)
                    mem[b][e] <= RGB_W'(default_entry(e, CHAN_W));
        end else if (wr_en) begin
            mem[bus.wr_bank][bus.wr_index] <= bus.wr_data;
        end
    end

    // ---------------- index remap ----------------
`ifdef TILE_PALETTE_CYCLE_EN
    palette_cycle_ctr #(
        .INDEX_W (INDEX_W),
        .CYC_LO  (CYC_LO),
        .CYC_HI  (CYC_HI)
    ) u_cyc (
        .clk        (Clk),
        .rst        (Reset),
        .frame_tick (bus.frame_tick),
        .idx_in     (s1_idx),
        .idx_out    (eff_idx)
    );
`else
    localparam int unused_cyc_len = CYC_HI - CYC_LO + 1;
    logic unused_frame_tick;
    assign unused_frame_tick = bus.frame_tick;
    assign eff_idx = s1_idx;
`endif

    // ---------------- 2-stage lookup ----------------
    // Stage 2 samples the array before this edge's write lands, so a read and
    // a write on the same edge return the old contents.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            vld_pipe <= '0;
            s1_bank  <= '0;
            s1_idx   <= '0;
            rgb_q    <= '0;
            trans_q  <= 1'b0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:1], bus.rd_valid};
            s1_bank  <= bus.pal_sel;
            s1_idx   <= bus.index;
            // Colour/transparent hold their last value across idle cycles.
            if (vld_pipe[1]) begin
                rgb_q   <= rd_bank_ok ? mem[s1_bank][eff_idx] : '0;
                trans_q <= (s1_idx == '0);
            end
        end
    end

    assign bus.red         = rgb_q[RGB_W-1 -: CHAN_W];
    assign bus.green       = rgb_q[2*CHAN_W-1 -: CHAN_W];
    assign bus.blue        = rgb_q[CHAN_W-1:0];
    assign bus.out_valid   = vld_pipe[STAGES];
    assign bus.transparent = trans_q;
endmodule
